// File: rtl/led_chaser_multi_if.sv
// led_chaser_multi_if -- control/status bundle for the LED chaser.
//   en    : run enable (low freezes pattern and prescaler)
//   mode  : pattern select (00 bounce, 01 rotl, 10 rotr, 11 fill/drain)
//   div   : step period minus one, in enabled clocks
//   led   : registered LED pattern
//   step  : one-cycle pulse, high in the cycle after a step moved led
//   wrap  : one-cycle pulse with step when led returns to the start pattern
// master drives the controls; slave (the chaser) drives the status.
interface led_chaser_multi_if #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 8
);
    logic             en;
    logic [1:0]       mode;
    logic [DIV_W-1:0] div;
    logic [WIDTH-1:0] led;
    logic             step;
    logic             wrap;

    modport master (output en, mode, div, input  led, step, wrap);
    modport slave  (input  en, mode, div, output led, step, wrap);
endinterface

// File: rtl/led_chaser_multi.sv
// led_chaser_multi -- multi-pattern LED chaser with an enabled-clock prescaler.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : led_chaser_multi_if.slave (en/mode/div in, led/step/wrap out)
// A prescaler ticks every div+1 enabled clocks; each tick advances the
// selected pattern by one step. A mode change reloads the new mode's start
// pattern immediately and swallows any coincident tick.
module led_chaser_multi #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    led_chaser_multi_if.slave   bus
);

    typedef enum logic [1:0] {
        M_BOUNCE = 2'b00,
        M_ROTL   = 2'b01,
        M_ROTR   = 2'b10,
        M_FILL   = 2'b11
    } mode_e;

    // Bounce direction and fill/drain phase, each a two-state machine.
    typedef enum logic {DIR_UP   = 1'b0, DIR_DOWN = 1'b1} dir_e;
    typedef enum logic {PH_FILL  = 1'b0, PH_DRAIN = 1'b1} ph_e;

    localparam logic [WIDTH-1:0] LSB_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] start_pat(input logic [1:0] m);
        case (mode_e'(m))
            M_ROTR:  return MSB_ONE;
            M_FILL:  return '0;
            default: return LSB_ONE;   // bounce and rotate-left
        endcase
    endfunction

    mode_e            mode_q, mode_d;
    logic [WIDTH-1:0] led_q,  led_d;
    logic [DIV_W-1:0] cnt_q,  cnt_d;
    dir_e             dir_q,  dir_d;
    ph_e              ph_q,   ph_d;
    logic             step_q, step_d;
    logic             wrap_q, wrap_d;

    logic             tick;
    logic [WIDTH-1:0] nxt;

    // >= rather than == so a div lowered below cnt ticks at once instead of
    // letting cnt run through 2^DIV_W.
    assign tick = bus.en && (cnt_q >= bus.div);

    always_comb begin
        mode_d = mode_e'(bus.mode);
        led_d  = led_q;
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        ph_d   = ph_q;
        step_d = 1'b0;
        wrap_d = 1'b0;
        nxt    = led_q;

        if (mode_e'(bus.mode) != mode_q) begin
            // Reload beats a coincident tick; no step/wrap pulse.
            led_d = start_pat(bus.mode);
            cnt_d = '0;
            dir_d = DIR_UP;
            ph_d  = PH_FILL;
        end else if (tick) begin
            cnt_d = '0;
            case (mode_q)
                M_BOUNCE: begin
                    // Ends are shown once: turn around on the step leaving them.
                    if (dir_q == DIR_UP) begin
                        if (led_q[WIDTH-1]) begin
                            nxt   = led_q >> 1;
                            dir_d = DIR_DOWN;
                        end else begin
                            nxt   = led_q << 1;
                        end
                    end else begin
                        if (led_q[0]) begin
                            nxt   = led_q << 1;
                            dir_d = DIR_UP;
                        end else begin
                            nxt   = led_q >> 1;
                        end
                    end
                end
                M_ROTL: nxt = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
                M_ROTR: nxt = {led_q[0], led_q[WIDTH-1:1]};
                default: begin
                    if (ph_q == PH_FILL) begin
                        nxt = {led_q[WIDTH-2:0], 1'b1};
                        if (&nxt) ph_d = PH_DRAIN;
                    end else begin
                        nxt = {led_q[WIDTH-2:0], 1'b0};
                        if (~|nxt) ph_d = PH_FILL;
                    end
                end
            endcase
            led_d  = nxt;
            step_d = 1'b1;
            wrap_d = (nxt == start_pat(mode_q));
        end else if (bus.en) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= mode_e'(bus.mode);
            led_q  <= start_pat(bus.mode);
            cnt_q  <= '0;
            dir_q  <= DIR_UP;
            ph_q   <= PH_FILL;
            step_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            led_q  <= led_d;
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            ph_q   <= ph_d;
            step_q <= step_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.led  = led_q;
    assign bus.step = step_q;
    assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_led_chaser_multi.sv
// tb_led_chaser_multi -- drives a WIDTH=8 and a WIDTH=4 chaser from the same
// controls and checks both against a position-index reference model: each
// mode is a closed-form pattern of a step index k within its period.
module tb_led_chaser_multi;
    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [1:0] mode;
    logic [7:0] div;

    always #5 clk = ~clk;

    led_chaser_multi_if #(.WIDTH(8), .DIV_W(8)) b8 ();
    led_chaser_multi_if #(.WIDTH(4), .DIV_W(8)) b4 ();

    assign b8.en = en;  assign b8.mode = mode;  assign b8.div = div;
    assign b4.en = en;  assign b4.mode = mode;  assign b4.div = div;

    led_chaser_multi #(.WIDTH(8), .DIV_W(8)) dut8 (.clk(clk), .reset(reset), .bus(b8));
    led_chaser_multi #(.WIDTH(4), .DIV_W(8)) dut4 (.clk(clk), .reset(reset), .bus(b4));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // ---- reference model ----
    function automatic int period(input int m, input int w);
        case (m)
            0:       return 2 * (w - 1);
            3:       return 2 * w;
            default: return w;
        endcase
    endfunction

    function automatic int pat(input int m, input int k, input int w);
        int full;
        full = (1 << w) - 1;
        case (m)
            0:       return 1 << ((k <= w - 1) ? k : 2 * (w - 1) - k);
            1:       return 1 << k;
            2:       return 1 << (w - 1 - k);
            default: return (k <= w) ? ((1 << k) - 1) : (full & ~((1 << (k - w)) - 1));
        endcase
    endfunction

    int m_mode, m_cnt, m_k8, m_k4;
    bit m_step, m_wrap8, m_wrap4;

    task automatic model_edge();
        if (reset || int'(mode) != m_mode) begin
            m_mode = int'(mode);
            m_cnt = 0; m_k8 = 0; m_k4 = 0;
            m_step = 0; m_wrap8 = 0; m_wrap4 = 0;
        end else if (en && m_cnt >= int'(div)) begin
            m_cnt = 0;
            m_k8 = (m_k8 + 1) % period(m_mode, 8);
            m_k4 = (m_k4 + 1) % period(m_mode, 4);
            m_step = 1; m_wrap8 = (m_k8 == 0); m_wrap4 = (m_k4 == 0);
        end else begin
            if (en) m_cnt++;
            m_step = 0; m_wrap8 = 0; m_wrap4 = 0;
        end
    endtask

    // One clock: model follows the edge, outputs sampled 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("led8",  32'(b8.led),  32'(pat(m_mode, m_k8, 8)));
        chk("step8", 32'(b8.step), 32'(m_step));
        chk("wrap8", 32'(b8.wrap), 32'(m_wrap8));
        chk("cnt8",  32'(dut8.cnt_q), 32'(m_cnt));
        chk("led4",  32'(b4.led),  32'(pat(m_mode, m_k4, 4)));
        chk("step4", 32'(b4.step), 32'(m_step));
        chk("wrap4", 32'(b4.wrap), 32'(m_wrap4));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; mode = 2'b00; div = 8'd0;
        run(2);
        chk("rst_led8", 32'(b8.led), 32'h01);
        reset = 1'b0;

        // bounce at full rate: one period plus a bit
        run(16);
        // bounce at div=3 with an en gap mid-count
        div = 8'd3; run(10);
        en = 1'b0; run(5);
        en = 1'b1; run(12);

        // fill/drain then rotate-right
        mode = 2'b11; div = 8'd0; run(20);
        mode = 2'b10; run(10);

        // mode change coinciding with a tick while led=08
        mode = 2'b01; run(4);
        chk("r028_pre", 32'(b8.led), 32'h08);
        mode = 2'b10; run(1);
        chk("r028_led",  32'(b8.led),  32'h80);
        chk("r028_step", 32'(b8.step), 32'h0);
        chk("r028_wrap", 32'(b8.wrap), 32'h0);

        // div lowered below current cnt
        mode = 2'b00; div = 8'd200; run(151);
        chk("r029_pre", 32'(dut8.cnt_q), 32'd150);
        div = 8'd10; run(1);
        chk("r029_step", 32'(b8.step), 32'h1);
        chk("r029_cnt",  32'(dut8.cnt_q), 32'h0);

        // reset mid-sequence in rotate-left at led=20
        mode = 2'b01; div = 8'd0; run(6);
        chk("r030_pre", 32'(b8.led), 32'h20);
        reset = 1'b1; run(1);
        reset = 1'b0;
        chk("r030_led",  32'(b8.led),  32'h01);
        chk("r030_step", 32'(b8.step), 32'h0);
        chk("r030_cnt",  32'(dut8.cnt_q), 32'h0);

        // randomized soak
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(99) == 0);
            if ($urandom_range(19) == 0) mode = 2'($urandom_range(3));
            en = ($urandom_range(9) < 8);
            if ($urandom_range(15) == 0)
                div = ($urandom_range(49) == 0) ? 8'($urandom_range(20, 40))
                                                : 8'($urandom_range(0, 6));
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
